// File: rtl/wallace_mult_seq_pkg.sv
// Shared types and sizing helpers for the sequential Wallace multiplier.
// Nibble count and index-counter width are derived from the operand width.
package wallace_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int numNibbles(input int width);
        return width / NIB_W;
    endfunction

    // A single-nibble operand still needs a one-bit index register.
    function automatic int idxWidth(input int width);
        int k;
        k = width / NIB_W;
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/wallace_mult_seq_if.sv
// Operand request and product response handshakes of the sequential multiplier.
// The requester/consumer side uses master; the multiplier uses slave.
interface wallace_mult_seq_if #(parameter int WIDTH = 8);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;
    logic                 busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );

endinterface

// File: rtl/wallace_mult_seq_tree.sv
// Combinational 4x4 unsigned Wallace multiplier: four partial-product rows
// reduced by two carry-save layers and one final carry-propagate add.
module Wallace_Tree_Multiplier_4x4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [8:0] Product
);

    logic [7:0] row [4];
    logic [7:0] s1, c1, s2, c2;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row[r] = {4'b0000, A & {4{B[r]}}} << r;
        end
        s1 = row[0] ^ row[1] ^ row[2];
        c1 = ((row[0] & row[1]) | (row[0] & row[2]) | (row[1] & row[2])) << 1;
        // Carries out of bit 7 cannot occur since 15*15 < 256.
        s2 = s1 ^ c1 ^ row[3];
        c2 = ((s1 & c1) | (s1 & row[3]) | (c1 & row[3])) << 1;
        Product = {1'b0, s2} + {1'b0, c2};
    end

endmodule

// File: rtl/wallace_mult_seq.sv
// WIDTH x WIDTH unsigned multiplier that time-shares one 4x4 Wallace tree,
// accumulating one shifted nibble-pair product per RUN cycle.
module wallace_mult_seq
    import wallace_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    wallace_mult_seq_if.slave  bus
);

    localparam int K  = numNibbles(WIDTH);
    localparam int IW = idxWidth(WIDTH);
    localparam int PW = 2 * WIDTH;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  aReg_q, aReg_d;
    logic [WIDTH-1:0]  bReg_q, bReg_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [IW-1:0]     i_q, i_d;
    logic [IW-1:0]     j_q, j_d;

    logic [3:0]        aNib, bNib;
    logic [8:0]        prodFull;
    logic [PW-1:0]     partial;
    logic              unusedProdMsb;

    assign aNib = 4'(aReg_q >> (NIB_W * int'(i_q)));
    assign bNib = 4'(bReg_q >> (NIB_W * int'(j_q)));

    Wallace_Tree_Multiplier_4x4 uTree (
        .A       (aNib),
        .B       (bNib),
        .Product (prodFull)
    );

    assign unusedProdMsb = prodFull[8];
    assign partial = {{(PW-8){1'b0}}, prodFull[7:0]} << (NIB_W * (int'(i_q) + int'(j_q)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            aReg_q  <= '0;
            bReg_q  <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            aReg_q  <= aReg_d;
            bReg_q  <= bReg_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    always_comb begin
        state_d = state_q;
        aReg_d  = aReg_q;
        bReg_d  = bReg_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    aReg_d  = bus.a;
                    bReg_d  = bus.b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + partial;
                // i sweeps fastest; the final step lands on i=j=K-1.
                if (i_q == IW'(K - 1)) begin
                    i_d = '0;
                    if (j_q == IW'(K - 1)) begin
                        j_d     = '0;
                        state_d = DONE;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.p         = acc_q;

endmodule

// File: tb/tb_wallace_mult_seq.sv
// Scoreboard bench for the sequential multiplier at WIDTH=8 and WIDTH=16.
// Expected products are pushed at the accept edge and popped at output.
module tb_wallace_mult_seq;

    logic clk;
    logic rst;

    wallace_mult_seq_if #(.WIDTH(8))  bus8 ();
    wallace_mult_seq_if #(.WIDTH(16)) bus16 ();

    wallace_mult_seq #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    wallace_mult_seq #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    int total;
    int bad;
    logic [15:0] sb8 [$];
    logic [31:0] sb16 [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operand pair on the 8-bit DUT for a single accept edge.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv);
        bus8.a = av;
        bus8.b = bv;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        sb8.push_back(16'(av) * 16'(bv));
    endtask

    task automatic issue16(input logic [15:0] av, input logic [15:0] bv);
        bus16.a = av;
        bus16.b = bv;
        bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        sb16.push_back(32'(av) * 32'(bv));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus8.in_valid = 1'b0;  bus8.out_ready = 1'b0;  bus8.a = '0;  bus8.b = '0;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.a = '0; bus16.b = '0;
        tick();
        tick();
        total++;
        if ({bus8.in_ready, bus8.out_valid, bus8.busy} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL reset8_flags: got %b expected 100", {bus8.in_ready, bus8.out_valid, bus8.busy});
        end
        total++;
        if (bus8.p !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset8_p: got %h expected 0000", bus8.p);
        end
        total++;
        if ({bus16.in_ready, bus16.out_valid, bus16.busy, bus16.p} !== {3'b100, 32'h0}) begin
            bad++;
            $display("[TB] FAIL reset16: got %b/%h expected 100/00000000", {bus16.in_ready, bus16.out_valid, bus16.busy}, bus16.p);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_max8();
        int lat;
        int readyErr;
        logic [15:0] exp;
        issue8(8'hFF, 8'hFF);
        lat = 0;
        readyErr = 0;
        while (!bus8.out_valid && lat < 40) begin
            if (bus8.in_ready !== 1'b0 || bus8.busy !== 1'b1) readyErr++;
            tick();
            lat++;
        end
        total++;
        if (lat !== 4) begin
            bad++;
            $display("[TB] FAIL max8_latency: got %0d expected 4", lat);
        end
        total++;
        if (readyErr !== 0 || bus8.in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL max8_in_ready_low: got %0d bad cycles expected 0", readyErr);
        end
        exp = sb8.pop_front();
        total++;
        if (bus8.p !== exp || exp !== 16'hFE01) begin
            bad++;
            $display("[TB] FAIL max8_p: got %h expected %h", bus8.p, exp);
        end
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        total++;
        if ({bus8.in_ready, bus8.out_valid, bus8.busy} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL max8_release: got %b expected 100", {bus8.in_ready, bus8.out_valid, bus8.busy});
        end
    endtask

    task automatic test_hold();
        int lat;
        int holdErr;
        logic [15:0] exp;
        issue8(8'h00, 8'hA5);
        lat = 0;
        while (!bus8.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== 4) begin
            bad++;
            $display("[TB] FAIL hold_latency: got %0d expected 4", lat);
        end
        exp = sb8.pop_front();
        holdErr = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus8.out_valid !== 1'b1 || bus8.p !== exp) holdErr++;
        end
        total++;
        if (holdErr !== 0 || bus8.p !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL hold_stable: got p=%h with %0d unstable cycles expected %h", bus8.p, holdErr, exp);
        end
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        total++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL hold_idle: got in_ready=%b out_valid=%b expected 1/0", bus8.in_ready, bus8.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] opA [2];
        logic [7:0] opB [2];
        int accCyc [2];
        int nAcc;
        int nOut;
        logic accEdge;
        logic hsEdge;
        logic [15:0] pv;
        logic [15:0] exp;
        opA[0] = 8'h12; opB[0] = 8'h34;
        opA[1] = 8'h0F; opB[1] = 8'h10;
        nAcc = 0;
        nOut = 0;
        accCyc[0] = 0;
        accCyc[1] = 0;
        bus8.a = opA[0];
        bus8.b = opB[0];
        bus8.in_valid = 1'b1;
        bus8.out_ready = 1'b1;
        for (int n = 0; n < 40 && nOut < 2; n++) begin
            accEdge = bus8.in_valid & bus8.in_ready;
            hsEdge  = bus8.out_valid & bus8.out_ready;
            pv      = bus8.p;
            tick();
            if (hsEdge) begin
                exp = (sb8.size() > 0) ? sb8.pop_front() : 16'hxxxx;
                total++;
                if (pv !== exp) begin
                    bad++;
                    $display("[TB] FAIL b2b_p%0d: got %h expected %h", nOut, pv, exp);
                end
                nOut++;
            end
            if (accEdge && nAcc < 2) begin
                sb8.push_back(16'(bus8.a) * 16'(bus8.b));
                accCyc[nAcc] = n;
                nAcc++;
                if (nAcc < 2) begin
                    bus8.a = opA[1];
                    bus8.b = opB[1];
                end else begin
                    bus8.in_valid = 1'b0;
                end
            end
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b0;
        total++;
        if (nOut !== 2 || nAcc !== 2) begin
            bad++;
            $display("[TB] FAIL b2b_count: got %0d outputs %0d accepts expected 2/2", nOut, nAcc);
        end
        total++;
        if (accCyc[1] - accCyc[0] !== 6) begin
            bad++;
            $display("[TB] FAIL b2b_interval: got %0d expected 6", accCyc[1] - accCyc[0]);
        end
        sb8.delete();
    endtask

    task automatic test_ignore_in_valid();
        int lat;
        int extra;
        logic [15:0] exp;
        issue8(8'h03, 8'h07);
        bus8.a = 8'h55;
        bus8.b = 8'h55;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        lat = 1;
        while (!bus8.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        exp = sb8.pop_front();
        total++;
        if (lat !== 4 || bus8.p !== exp || exp !== 16'h0015) begin
            bad++;
            $display("[TB] FAIL ignore_p: got %h after %0d cycles expected %h after 4", bus8.p, lat, exp);
        end
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) extra++;
            tick();
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("[TB] FAIL ignore_no_extra: got %0d non-idle cycles expected 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [15:0] exp;
        issue8(8'hC8, 8'h64);
        tick();
        rst = 1'b1;
        #1;
        total++;
        if ({bus8.out_valid, bus8.in_ready, bus8.busy} !== 3'b010 || bus8.p !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL midreset_async: got flags %b p=%h expected 010 p=0000", {bus8.out_valid, bus8.in_ready, bus8.busy}, bus8.p);
        end
        sb8.delete();
        tick();
        rst = 1'b0;
        tick();
        issue8(8'hC8, 8'h64);
        lat = 0;
        while (!bus8.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        exp = sb8.pop_front();
        total++;
        if (lat !== 4 || bus8.p !== exp || exp !== 16'h4E20) begin
            bad++;
            $display("[TB] FAIL midreset_fresh: got %h after %0d cycles expected %h after 4", bus8.p, lat, exp);
        end
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
    endtask

    task automatic test_max16();
        int lat;
        logic [31:0] exp;
        issue16(16'hFFFF, 16'hFFFF);
        lat = 0;
        while (!bus16.out_valid && lat < 60) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== 16) begin
            bad++;
            $display("[TB] FAIL max16_latency: got %0d expected 16", lat);
        end
        exp = sb16.pop_front();
        total++;
        if (bus16.p !== exp || exp !== 32'hFFFE0001) begin
            bad++;
            $display("[TB] FAIL max16_p: got %h expected %h", bus16.p, exp);
        end
        bus16.out_ready = 1'b1;
        tick();
        bus16.out_ready = 1'b0;
    endtask

    task automatic test_random16();
        int lat;
        logic [15:0] av;
        logic [15:0] bv;
        logic [31:0] exp;
        bus16.out_ready = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            if (n == 0) av = 16'h0000;
            if (n == 1) bv = 16'h0001;
            issue16(av, bv);
            lat = 0;
            while (!bus16.out_valid && lat < 60) begin
                tick();
                lat++;
            end
            exp = sb16.pop_front();
            total++;
            if (lat !== 16 || bus16.p !== exp) begin
                bad++;
                $display("[TB] FAIL rand16_%0d: got %h after %0d cycles expected %h (a=%h b=%h)", n, bus16.p, lat, exp, av, bv);
            end
            bus16.out_ready = 1'b1;
            tick();
            bus16.out_ready = 1'b0;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_max8();
        test_hold();
        test_back_to_back();
        test_ignore_in_valid();
        test_reset_mid();
        test_max16();
        test_random16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wallace_mult_seq.md
# wallace_mult_seq

Multi-cycle unsigned multiplier controller. It time-shares one instance of the team's combinational 4x4 Wallace multiplier to compute a WIDTH x WIDTH product. Each cycle it feeds one nibble pair and accumulates the shifted 8-bit partial product. It sits between a valid/ready requester and a valid/ready consumer, and is intended for area-constrained paths where one small tree replaces a full-width array.

## Interface
- WIDTH, 8: operand width in bits; legal values 8, 12, 16 (must be a multiple of 4); K = WIDTH/4 nibbles per operand.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, asynchronous and active-high; one clock; reset is asynchronous and active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product valid; high only in DONE.
- out_ready  input  1  consumer accepts product.
- p  output  2*WIDTH  product a*b; the registered accumulator value.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1, capture a and b into registers.
  - Clear the accumulator, set nibble indices i=0, j=0, go to RUN.
- RUN, one step per cycle:
  - Drive the 4x4 multiplier with a_reg[4i+3:4i] and b_reg[4j+3:4j].
  - Take the multiplier output Product[7:0]; Product[8] is always 0 for 4-bit operands and is ignored.
  - Update acc <= acc + (Product[7:0] << 4*(i+j)), zero-extended to 2*WIDTH.
  - Step order: i increments fastest. When i=K-1, i wraps to 0 and j increments.
  - After the step with i=j=K-1, go to DONE.
- DONE:
  - out_valid=1 and p=acc, both held stable until the handshake.
  - When out_ready=1, go to IDLE. The accumulator is retained, so p keeps the last product.
- Width rule: the accumulator is 2*WIDTH bits. The largest sum, (2^WIDTH-1)^2, fits, so the accumulator can never overflow and no carry-out is needed.
- in_valid while not in IDLE: ignored, because in_ready=0. The requester holds its data; nothing is captured.
- out_ready=1 before DONE: no effect.
- Zero operands: the full K^2 steps are still executed; there is no early termination.
- Reset values: state=IDLE, i=j=0, acc=0, a_reg=b_reg=0, in_ready=1, out_valid=0, busy=0, p=0.
- Reset mid-operation (RUN or DONE): the operation is aborted; outputs take their reset values asynchronously; no out_valid pulse.

## Timing
- Accept edge: the edge with in_valid & in_ready.
- RUN occupies the next K^2 cycles.
- out_valid rises immediately after the K^2-th RUN edge.
  - Latency from accept edge to out_valid is K^2 cycles: 4 for WIDTH=8, 9 for WIDTH=12, 16 for WIDTH=16.
- Release: the out handshake edge returns the FSM to IDLE; in_ready=1 on the following cycle.
- Minimum issue interval is K^2+2 cycles (accept, K^2 RUN, DONE with out_ready=1).
- The multiplier path is combinational within one cycle: nibble mux, 4x4 tree, shifter, accumulator add.
- in_ready, out_valid and busy are decoded directly from registered state; there are no combinational paths from inputs to outputs.

## Structure
- Package wallace_seq_pkg:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding.
  - NIB_W=4.
  - localparam function for K and the index-counter width, $clog2(K) with a minimum of 1.
- One sub-module: Wallace_Tree_Multiplier_4x4 (ports A[3:0], B[3:0], Product[8:0]), instantiated once.
- Nibble select, shift and accumulate stay in this module; there is no separate adder sub-module.

## Test plan
- Reset, then WIDTH=8, a=0xFF, b=0xFF with in_valid for one cycle -> out_valid exactly 4 cycles after accept, p=0xFE01; in_ready=0 throughout RUN/DONE.
- a=0x00, b=0xA5 -> p=0x0000 after 4 cycles; out_valid held while out_ready=0 for 3 cycles, p stable; IDLE the cycle after out_ready=1.
- Back-to-back: in_valid held high with (0x12,0x34) then (0x0F,0x10), out_ready=1 -> p=0x03A8 then p=0x00F0; second accept 6 cycles after the first.
- in_valid pulsed with a=0x55, b=0x55 during RUN of (0x03,0x07) -> result 0x0015; the pulse is ignored; no extra out_valid.
- Assert rst in the 2nd RUN cycle of (0xC8,0x64) -> out_valid=0, p=0, in_ready=1 immediately; after release a fresh (0xC8,0x64) yields 0x4E20.
- WIDTH=16, a=0xFFFF, b=0xFFFF -> out_valid 16 cycles after accept, p=0xFFFE0001; random sweep of 1000 pairs checked against a*b.
